// File: rtl/adc_stream_pkg.sv
// Shared types and default widths for the ADC echo acquisition path.
package adc_stream_pkg;

    localparam int unsigned DEF_DATA_W    = 16;
    localparam int unsigned DEF_CNT_W     = 32;
    localparam int unsigned DEF_BUF_DEPTH = 4;

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StDelay,
        StAcq,
        StDone
    } state_e;

endpackage

// File: rtl/st_out_buf.sv
// Show-ahead synchronous FIFO feeding the Avalon-ST source. The head entry and
// the valid flag come straight from registers, so nothing on the output side
// depends combinationally on the consumer's ready.
module st_out_buf #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count_q == (AW + 1)'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a push onto a full buffer still lands.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    // Storage, pointers and occupancy; flush empties the buffer but keeps contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + (AW + 1)'(wr_en) - (AW + 1)'(rd_en);
        end
    end

endmodule

// File: rtl/adc_echo_streamer.sv
// Gates the raw ADC stream into per-echo bursts: wait rx_delay after each echo
// trigger, capture samples_per_echo valid samples, repeat echoes_per_scan times.
// Samples that find the output buffer full are dropped and flagged, never stalled.
module adc_echo_streamer
    import adc_stream_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned BUF_DEPTH = DEF_BUF_DEPTH
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              start,
    input  logic              abort,
    input  logic              echo_trig,
    input  logic [CNT_W-1:0]  rx_delay,
    input  logic [CNT_W-1:0]  samples_per_echo,
    input  logic [CNT_W-1:0]  echoes_per_scan,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_dv,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [CNT_W-1:0]  echo_cnt
);

    state_e           state_q;
    logic [CNT_W-1:0] cfg_delay_q;
    logic [CNT_W-1:0] cfg_spe_q;
    logic [CNT_W-1:0] cfg_eps_q;
    logic [CNT_W-1:0] dly_cnt_q;
    logic [CNT_W-1:0] smp_cnt_q;
    logic [CNT_W-1:0] echo_cnt_q;
    logic             overflow_q;
    logic             done_q;
    logic             busy_q;

    logic             push;
    logic             pop;
    logic             buf_full;
    logic             buf_empty;
    logic             last_smp;
    logic             last_echo;

    assign push      = (state_q == StAcq) && adc_dv && !abort;
    assign pop       = st_valid && st_ready;
    assign st_valid  = !buf_empty;
    assign last_smp  = (smp_cnt_q + CNT_W'(1)) == cfg_spe_q;
    assign last_echo = (echo_cnt_q + CNT_W'(1)) == cfg_eps_q;

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign echo_cnt = echo_cnt_q;

    st_out_buf #(
        .WIDTH (DATA_W),
        .DEPTH (BUF_DEPTH)
    ) u_out_buf (
        .clk   (clk_clk),
        .rst   (reset_reset),
        .flush (abort),
        .push  (push),
        .wdata (adc_data),
        .pop   (pop),
        .rdata (st_data),
        .full  (buf_full),
        .empty (buf_empty)
    );

    // Scan sequencer: config latch, delay/sample/echo counters and registered flags.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q     <= StIdle;
            cfg_delay_q <= '0;
            cfg_spe_q   <= '0;
            cfg_eps_q   <= '0;
            dly_cnt_q   <= '0;
            smp_cnt_q   <= '0;
            echo_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Dropped sample still counts below, so echo timing never slips.
            if (push && buf_full && !pop) begin
                overflow_q <= 1'b1;
            end
            if (abort) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            cfg_delay_q <= rx_delay;
                            cfg_spe_q   <= samples_per_echo;
                            cfg_eps_q   <= echoes_per_scan;
                            echo_cnt_q  <= '0;
                            overflow_q  <= 1'b0;
                            state_q     <= StArmed;
                            busy_q      <= 1'b1;
                        end
                    end
                    StArmed: begin
                        // Degenerate scans finish without waiting for a trigger.
                        if (cfg_spe_q == '0 || cfg_eps_q == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else if (echo_trig) begin
                            smp_cnt_q <= '0;
                            if (cfg_delay_q == '0) begin
                                state_q <= StAcq;
                            end else begin
                                dly_cnt_q <= cfg_delay_q - CNT_W'(1);
                                state_q   <= StDelay;
                            end
                        end
                    end
                    StDelay: begin
                        if (dly_cnt_q == '0) begin
                            state_q <= StAcq;
                        end else begin
                            dly_cnt_q <= dly_cnt_q - CNT_W'(1);
                        end
                    end
                    StAcq: begin
                        if (adc_dv) begin
                            smp_cnt_q <= smp_cnt_q + CNT_W'(1);
                            if (last_smp) begin
                                echo_cnt_q <= echo_cnt_q + CNT_W'(1);
                                if (last_echo) begin
                                    state_q <= StDone;
                                    done_q  <= 1'b1;
                                end else begin
                                    state_q <= StArmed;
                                end
                            end
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_echo_streamer.sv
// Directed bench for adc_echo_streamer. Stimulus loops push the samples they
// expect to see on the stream into a queue; a monitor on the falling edge pops
// and compares on every handshake.
module tb_adc_echo_streamer;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic        start;
    logic        abort;
    logic        echo_trig;
    logic [31:0] rx_delay;
    logic [31:0] samples_per_echo;
    logic [31:0] echoes_per_scan;
    logic [15:0] adc_data;
    logic        adc_dv;
    logic [15:0] st_data;
    logic        st_valid;
    logic        st_ready;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [31:0] echo_cnt;

    int          checks = 0;
    int          errors = 0;
    int          done_count = 0;
    logic [15:0] sb [$];

    always #5 clk_clk = ~clk_clk;

    adc_echo_streamer #(
        .DATA_W    (16),
        .CNT_W     (32),
        .BUF_DEPTH (4)
    ) dut (
        .clk_clk          (clk_clk),
        .reset_reset      (reset_reset),
        .start            (start),
        .abort            (abort),
        .echo_trig        (echo_trig),
        .rx_delay         (rx_delay),
        .samples_per_echo (samples_per_echo),
        .echoes_per_scan  (echoes_per_scan),
        .adc_data         (adc_data),
        .adc_dv           (adc_dv),
        .st_data          (st_data),
        .st_valid         (st_valid),
        .st_ready         (st_ready),
        .busy             (busy),
        .done             (done),
        .overflow         (overflow),
        .echo_cnt         (echo_cnt)
    );

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Scoreboard monitor: every stream handshake must match the queue head.
    always @(negedge clk_clk) begin
        logic [15:0] exp_d;
        if (!reset_reset) begin
            if (done) done_count++;
            if (st_valid && st_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL stream_unexpected: got data %0h, expected no transfer", st_data);
                end else begin
                    exp_d = sb.pop_front();
                    if (st_data !== exp_d) begin
                        errors++;
                        $display("FAIL stream_data: got %0h, expected %0h", st_data, exp_d);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic quiet(input int n);
        start     = 1'b0;
        abort     = 1'b0;
        echo_trig = 1'b0;
        adc_dv    = 1'b0;
        st_ready  = 1'b1;
        repeat (n) next_cycle();
    endtask

    initial begin
        reset_reset      = 1'b1;
        start            = 1'b0;
        abort            = 1'b0;
        echo_trig        = 1'b0;
        rx_delay         = 32'd0;
        samples_per_echo = 32'd0;
        echoes_per_scan  = 32'd0;
        adc_data         = 16'd0;
        adc_dv           = 1'b0;
        st_ready         = 1'b1;
        repeat (3) @(posedge clk_clk);
        #1 reset_reset = 1'b0;
        @(negedge clk_clk);
        chk("reset_st_valid", 32'(st_valid), 32'd0);
        chk("reset_st_data", 32'(st_data), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_echo_cnt", echo_cnt, 32'd0);
        next_cycle();

        // Basic scan: delay 3, 4 samples x 2 echoes, triggers at k=2 and k=12.
        rx_delay = 32'd3; samples_per_echo = 32'd4; echoes_per_scan = 32'd2;
        done_count = 0;
        for (int k = 0; k < 24; k++) begin
            start     = (k == 0);
            echo_trig = (k == 2) || (k == 12);
            adc_dv    = 1'b1;
            st_ready  = 1'b1;
            adc_data  = 16'h0100 + 16'(k);
            if ((k >= 6 && k <= 9) || (k >= 16 && k <= 19)) sb.push_back(adc_data);
            @(negedge clk_clk);
            if (k == 6)  chk("basic_busy", 32'(busy), 32'd1);
            if (k == 19) chk("basic_done_early", 32'(done), 32'd0);
            if (k == 20) chk("basic_done", 32'(done), 32'd1);
            next_cycle();
        end
        chk("basic_echo_cnt", echo_cnt, 32'd2);
        chk("basic_done_count", 32'(done_count), 32'd1);
        chk("basic_drained", 32'(sb.size()), 32'd0);
        chk("basic_busy_end", 32'(busy), 32'd0);
        chk("basic_overflow", 32'(overflow), 32'd0);
        quiet(2);

        // Back-pressure: ready low k=3..8, buffer of 4 fills, k=7,8 are dropped.
        rx_delay = 32'd0; samples_per_echo = 32'd8; echoes_per_scan = 32'd1;
        done_count = 0;
        for (int k = 0; k < 18; k++) begin
            start     = (k == 0);
            echo_trig = (k == 2);
            adc_dv    = 1'b1;
            st_ready  = !(k >= 3 && k <= 8);
            adc_data  = 16'h0200 + 16'(k);
            if ((k >= 3 && k <= 6) || k == 9 || k == 10) sb.push_back(adc_data);
            @(negedge clk_clk);
            if (k == 6)  chk("bp_overflow_clear", 32'(overflow), 32'd0);
            if (k == 7)  chk("bp_hold_valid", 32'(st_valid), 32'd1);
            if (k == 7)  chk("bp_hold_data", 32'(st_data), 32'h0203);
            if (k == 8)  chk("bp_overflow_set", 32'(overflow), 32'd1);
            if (k == 11) chk("bp_done", 32'(done), 32'd1);
            next_cycle();
        end
        chk("bp_echo_cnt", echo_cnt, 32'd1);
        chk("bp_overflow_sticky", 32'(overflow), 32'd1);
        chk("bp_done_count", 32'(done_count), 32'd1);
        chk("bp_drained", 32'(sb.size()), 32'd0);
        quiet(2);

        // Zero-length scan: done two cycles after start, never any stream data.
        rx_delay = 32'd1; samples_per_echo = 32'd0; echoes_per_scan = 32'd1;
        done_count = 0;
        for (int k = 0; k < 6; k++) begin
            start     = (k == 0);
            echo_trig = (k == 1);
            adc_dv    = 1'b1;
            adc_data  = 16'h0300 + 16'(k);
            @(negedge clk_clk);
            if (k == 1) chk("zero_done_early", 32'(done), 32'd0);
            if (k == 2) chk("zero_done", 32'(done), 32'd1);
            if (k == 2) chk("zero_no_valid", 32'(st_valid), 32'd0);
            if (k == 3) chk("zero_busy_low", 32'(busy), 32'd0);
            next_cycle();
        end
        chk("zero_done_count", 32'(done_count), 32'd1);
        chk("zero_overflow_cleared", 32'(overflow), 32'd0);
        quiet(2);

        // Abort with two samples buffered under back-pressure.
        rx_delay = 32'd0; samples_per_echo = 32'd8; echoes_per_scan = 32'd1;
        done_count = 0;
        for (int k = 0; k < 10; k++) begin
            start     = (k == 0);
            echo_trig = (k == 2);
            abort     = (k == 5);
            adc_dv    = (k == 3) || (k == 4) || (k == 5);
            st_ready  = 1'b0;
            adc_data  = 16'h0400 + 16'(k);
            @(negedge clk_clk);
            if (k == 5) chk("abort_valid_before", 32'(st_valid), 32'd1);
            if (k == 6) chk("abort_valid_after", 32'(st_valid), 32'd0);
            if (k == 6) chk("abort_busy", 32'(busy), 32'd0);
            next_cycle();
        end
        quiet(4);
        chk("abort_no_done", 32'(done_count), 32'd0);
        chk("abort_echo_cnt", echo_cnt, 32'd0);

        // Trigger timing: zero delay, dv toggling, stray triggers and starts.
        rx_delay = 32'd0; samples_per_echo = 32'd3; echoes_per_scan = 32'd1;
        done_count = 0;
        for (int k = 0; k < 12; k++) begin
            start     = (k == 0) || (k == 4);
            echo_trig = (k == 2) || (k == 4) || (k == 6) || (k == 8);
            adc_dv    = (k % 2) == 1;
            adc_data  = 16'h0500 + 16'(k);
            if (k == 3 || k == 5 || k == 7) sb.push_back(adc_data);
            @(negedge clk_clk);
            if (k == 7) chk("trig_done_early", 32'(done), 32'd0);
            if (k == 8) chk("trig_done", 32'(done), 32'd1);
            next_cycle();
        end
        chk("trig_echo_cnt", echo_cnt, 32'd1);
        chk("trig_done_count", 32'(done_count), 32'd1);
        chk("trig_drained", 32'(sb.size()), 32'd0);
        quiet(2);

        // Reset during DELAY, then a clean scan with delay 1 and 2 samples.
        samples_per_echo = 32'd2; echoes_per_scan = 32'd1;
        done_count = 0;
        for (int k = 0; k < 16; k++) begin
            rx_delay    = (k < 6) ? 32'd5 : 32'd1;
            reset_reset = (k == 4);
            start       = (k == 0) || (k == 6);
            echo_trig   = (k == 2) || (k == 8);
            adc_dv      = 1'b1;
            adc_data    = 16'h0600 + 16'(k);
            if (k == 10 || k == 11) sb.push_back(adc_data);
            @(negedge clk_clk);
            if (k == 4) chk("rst_busy_before", 32'(busy), 32'd1);
            if (k == 5) begin
                chk("rst_st_valid", 32'(st_valid), 32'd0);
                chk("rst_st_data", 32'(st_data), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_overflow", 32'(overflow), 32'd0);
                chk("rst_echo_cnt", echo_cnt, 32'd0);
            end
            if (k == 12) chk("rst_scan_done", 32'(done), 32'd1);
            next_cycle();
        end
        chk("rst_scan_echo_cnt", echo_cnt, 32'd1);
        chk("rst_scan_done_count", 32'(done_count), 32'd1);
        chk("rst_scan_drained", 32'(sb.size()), 32'd0);
        quiet(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_echo_streamer.md
# adc_echo_streamer

Acquisition front-end that turns the raw ADC sample stream into the gated, per-echo Avalon-ST stream consumed by the ADC FIFO sink (`adc_fifo_in_*`) of the SoC system. On each echo trigger from the pulse sequencer it waits a programmable receive delay, then captures a programmed number of samples. This repeats for a programmed number of echoes per scan. A small output buffer absorbs sink back-pressure. Samples that cannot be buffered set a sticky overflow flag instead of stalling acquisition.

## Interface
- `DATA_W`, 16, ADC sample width (matches `adc_fifo_in_data`)
- `CNT_W`, 32, width of delay/sample/echo counters (matches 32-bit PIO exports)
- `BUF_DEPTH`, 4, output buffer entries, power of two, ≥2

Ports:
- `clk_clk` in 1: sole clock, ADC sample clock domain
- `reset_reset` in 1: synchronous, active-high reset
- `start` in 1: one-cycle pulse, begins a scan
- `abort` in 1: one-cycle pulse, terminates the scan
- `echo_trig` in 1: one-cycle pulse per echo from the sequencer
- `rx_delay` in CNT_W: cycles from `echo_trig` to the first captured sample
- `samples_per_echo` in CNT_W: samples captured per echo
- `echoes_per_scan` in CNT_W: echoes per scan
- `adc_data` in DATA_W: ADC sample
- `adc_dv` in 1: `adc_data` is valid this cycle
- `st_data` out DATA_W: to `adc_fifo_in_data`
- `st_valid` out 1: to `adc_fifo_in_valid`
- `st_ready` in 1: from `adc_fifo_in_ready`
- `busy` out 1: state ≠ IDLE
- `done` out 1: one-cycle pulse at scan completion
- `overflow` out 1: sticky, sample dropped because buffer was full
- `echo_cnt` out CNT_W: echoes completed in the current scan

## Operation
- The three configuration inputs are latched on `start` and ignored for the rest of the scan.
- States and transitions:
  - IDLE → ARMED on `start`. Clears `echo_cnt` and `overflow`. If latched `samples_per_echo`==0 or `echoes_per_scan`==0, goes to DONE instead.
  - ARMED → DELAY on `echo_trig`, or directly → ACQ if `rx_delay`==0.
  - DELAY: counts cycles, not `adc_dv`. → ACQ after exactly `rx_delay` cycles after the trigger cycle.
  - ACQ: each `adc_dv` cycle writes `adc_data` into the buffer and increments the sample count. On sample number `samples_per_echo`, increments `echo_cnt`. Goes → DONE if `echo_cnt`+1 == `echoes_per_scan`, otherwise → ARMED.
  - DONE: asserts `done` for one cycle, then → IDLE.
- `echo_trig` outside ARMED is ignored. `start` outside IDLE is ignored.
- `abort` in any state → IDLE next cycle and flushes the buffer. `st_valid` drops the following cycle. `done` is not asserted. `overflow` and `echo_cnt` hold.
- Full buffer on a write: the sample is dropped, `overflow` is set, and the sample still counts toward `samples_per_echo`. Echo timing never slips.
- Simultaneous write and read on a full buffer: the read frees an entry in the same cycle, so the write succeeds (no overflow).

## Timing
- Reset values: `st_valid`=0, `st_data`=0, `busy`=0, `done`=0, `overflow`=0, `echo_cnt`=0. Buffer empty, state IDLE.
- Latency: a sample written in cycle N is presented with `st_valid`=1 in cycle N+1 when the buffer is empty.
- Avalon-ST handshake:
  - A transfer occurs when `st_valid`&&`st_ready`.
  - While `st_valid`&&!`st_ready`, `st_data` is held stable.
  - `st_valid` never depends combinationally on `st_ready`.
- Sustained throughput is one sample per cycle while `st_ready`=1.
- Trigger timing: with `echo_trig` in cycle T, the first sample eligible for capture is at cycle T+1+`rx_delay`. With `rx_delay`=0, it is T+1.
- `done` is asserted in the cycle after the last sample write. The buffer may still hold data at that point.

## Structure
- Shared package `adc_stream_pkg`:
  - state enum (IDLE, ARMED, DELAY, ACQ, DONE)
  - `DATA_W` / `CNT_W` defaults
- Sub-module `st_out_buf`: synchronous FIFO, registered output, show-ahead. Ports: push, pop, flush, full, empty.
- Top level contains the FSM, latched configuration, counters and overflow logic.

## Test plan
- Basic scan: `rx_delay`=3, `samples_per_echo`=4, `echoes_per_scan`=2, `adc_dv`=1, `st_ready`=1, ramp `adc_data` → 8 samples out. The first is the sample at T+4 after each trigger. `echo_cnt`=2. One `done` pulse.
- Back-pressure: `st_ready`=0 for 6 cycles during ACQ with `BUF_DEPTH`=4 → first 4 samples delivered in order. Samples 5–6 dropped. `overflow`=1. Echo still ends after `samples_per_echo` samples.
- Zero-length: `samples_per_echo`=0 → `done` 2 cycles after `start`. No `st_valid`. `busy` low after `done`.
- Abort mid-ACQ with 2 buffered samples → IDLE next cycle. `st_valid`=0 the cycle after. No `done`.
- Trigger timing: `rx_delay`=0, `echo_trig` repeated during ACQ, and `adc_dv` toggling 1/0 → capture starts T+1. Extra triggers ignored. Only `adc_dv` cycles are counted.
- Reset mid-scan: `reset_reset` asserted during DELAY → all outputs at reset values the next cycle. A following `start` runs a clean scan.
